// File: rtl/deck_controller_if.sv
// Deck RAM port bundle: the controller is the sole master, the RAM is the slave.
// RAM acts on the cycle mem_clk=1; read data (mem_q) is valid the following cycle.
interface deck_controller_if;
  logic [5:0] mem_addr;
  logic [3:0] mem_data;
  logic       mem_write;
  logic       mem_clk;
  logic [3:0] mem_q;

  modport master (
    output mem_addr, mem_data, mem_write, mem_clk,
    input  mem_q
  );

  modport slave (
    input  mem_addr, mem_data, mem_write, mem_clk,
    output mem_q
  );
endinterface

// File: rtl/deck_controller.sv
// Deck controller: fills the deck RAM with an ordered deck, lets the Shuffler own the RAM port
// while feeding it LFSR-derived swap addresses, then serves one-card draws in order.
module deck_controller #(
  parameter int unsigned DECK_SIZE  = 52,
  parameter int unsigned RANK_COUNT = 13,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       i_Rst_n,
  input  logic       i_NewGame,
  input  logic       i_DrawReq,
  output logic       o_DrawAck,
  output logic [3:0] o_Card,
  output logic       o_DeckReady,
  output logic       o_DeckEmpty,
  output logic [5:0] o_CardsLeft,
  output logic       o_ActShuffler,
  output logic [5:0] o_Addr_J,
  input  logic       i_Shuffled,
  input  logic [5:0] i_ShufAddr,
  input  logic [3:0] i_ShufData,
  input  logic       i_ShufWrite,
  input  logic       i_ShufMemClk,
  deck_controller_if.master mem
);

  localparam logic [5:0] DeckSz  = 6'(DECK_SIZE);
  localparam logic [5:0] LastIdx = 6'(DECK_SIZE - 1);
  localparam logic [3:0] RankCnt = 4'(RANK_COUNT);

  function automatic logic [5:0] reduce_j(input logic [5:0] r);
    return (r >= DeckSz) ? r - DeckSz : r;
  endfunction

  localparam logic [5:0] JSeed = (LFSR_SEED[5:0] >= DeckSz) ? LFSR_SEED[5:0] - DeckSz
                                                             : LFSR_SEED[5:0];

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StShuffle,
    StReady,
    StDrawRd,
    StDrawLat
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [5:0]  j_q, j_d;
  logic        parity_q, parity_d;
  logic [5:0]  fill_idx_q, fill_idx_d;
  logic        fill_phase_q, fill_phase_d;
  logic [3:0]  fill_rank_q, fill_rank_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [5:0]  left_q, left_d;
  logic [3:0]  card_q, card_d;

  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= StIdle;
      lfsr_q       <= LFSR_SEED;
      j_q          <= JSeed;
      parity_q     <= 1'b0;
      fill_idx_q   <= '0;
      fill_phase_q <= 1'b0;
      fill_rank_q  <= 4'd1;
      ptr_q        <= '0;
      left_q       <= '0;
      card_q       <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      j_q          <= j_d;
      parity_q     <= parity_d;
      fill_idx_q   <= fill_idx_d;
      fill_phase_q <= fill_phase_d;
      fill_rank_q  <= fill_rank_d;
      ptr_q        <= ptr_d;
      left_q       <= left_d;
      card_q       <= card_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    j_d           = j_q;
    parity_d      = parity_q;
    fill_idx_d    = fill_idx_q;
    fill_phase_d  = fill_phase_q;
    fill_rank_d   = fill_rank_q;
    ptr_d         = ptr_q;
    left_d        = left_q;
    card_d        = card_q;
    mem.mem_addr  = '0;
    mem.mem_data  = '0;
    mem.mem_write = 1'b0;
    mem.mem_clk   = 1'b0;
    o_DrawAck     = 1'b0;
    o_ActShuffler = 1'b0;
    o_DeckReady   = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_NewGame) begin
          state_d      = StFill;
          fill_idx_d   = '0;
          fill_phase_d = 1'b0;
          fill_rank_d  = 4'd1;
        end
      end

      StFill: begin
        mem.mem_addr  = fill_idx_q;
        mem.mem_data  = fill_rank_q;
        mem.mem_write = 1'b1;
        mem.mem_clk   = fill_phase_q;
        fill_phase_d  = ~fill_phase_q;
        if (fill_phase_q) begin
          if (fill_idx_q == LastIdx) begin
            state_d  = StShuffle;
            j_d      = reduce_j(lfsr_q[5:0]);
            parity_d = 1'b0;
          end else begin
            fill_idx_d  = fill_idx_q + 6'd1;
            fill_rank_d = (fill_rank_q == RankCnt) ? 4'd1 : fill_rank_q + 4'd1;
          end
        end
      end

      StShuffle: begin
        o_ActShuffler = 1'b1;
        mem.mem_addr  = i_ShufAddr;
        mem.mem_data  = i_ShufData;
        mem.mem_write = i_ShufWrite;
        mem.mem_clk   = i_ShufMemClk;
        // Each swap is a pair of writes; J must hold until the pair completes.
        if (i_ShufMemClk && i_ShufWrite) begin
          parity_d = ~parity_q;
          if (parity_q) j_d = reduce_j(lfsr_q[5:0]);
        end
        if (i_Shuffled) begin
          state_d = StReady;
          ptr_d   = '0;
          left_d  = DeckSz;
        end
      end

      StReady: begin
        o_DeckReady = 1'b1;
        if (i_NewGame) begin
          state_d      = StFill;
          fill_idx_d   = '0;
          fill_phase_d = 1'b0;
          fill_rank_d  = 4'd1;
          left_d       = '0;
          ptr_d        = '0;
        end else if (i_DrawReq && (left_q != 6'd0)) begin
          state_d = StDrawRd;
        end
      end

      StDrawRd: begin
        o_DeckReady  = 1'b1;
        mem.mem_addr = ptr_q;
        mem.mem_clk  = 1'b1;
        state_d      = StDrawLat;
      end

      StDrawLat: begin
        o_DeckReady = 1'b1;
        o_DrawAck   = 1'b1;
        card_d      = mem.mem_q;
        ptr_d       = ptr_q + 6'd1;
        left_d      = left_q - 6'd1;
        state_d     = StReady;
      end

      default: state_d = StIdle;
    endcase
  end

  // Card is presented straight from RAM during the ack cycle, then held.
  assign o_Card      = (state_q == StDrawLat) ? mem.mem_q : card_q;
  assign o_DeckEmpty = (state_q == StReady) && (left_q == 6'd0);
  assign o_CardsLeft = left_q;
  assign o_Addr_J    = j_q;

endmodule

// File: tb/tb_deck_controller.sv
// Bench for deck_controller: RAM and Shuffler models, draw scoreboard with a separate monitor.
module tb_deck_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       new_game, draw_req, shuffled;
  logic [5:0] shuf_addr;
  logic [3:0] shuf_data;
  logic       shuf_write, shuf_mclk;
  logic       draw_ack, deck_ready, deck_empty, act_shuf;
  logic [3:0] card;
  logic [5:0] cards_left, addr_j;

  always #5 clk = ~clk;

  deck_controller_if mem_if ();

  deck_controller dut (
    .clk           (clk),
    .i_Rst_n       (rst_n),
    .i_NewGame     (new_game),
    .i_DrawReq     (draw_req),
    .o_DrawAck     (draw_ack),
    .o_Card        (card),
    .o_DeckReady   (deck_ready),
    .o_DeckEmpty   (deck_empty),
    .o_CardsLeft   (cards_left),
    .o_ActShuffler (act_shuf),
    .o_Addr_J      (addr_j),
    .i_Shuffled    (shuffled),
    .i_ShufAddr    (shuf_addr),
    .i_ShufData    (shuf_data),
    .i_ShufWrite   (shuf_write),
    .i_ShufMemClk  (shuf_mclk),
    .mem           (mem_if.master)
  );

  logic [3:0] ram [64];
  always @(posedge clk) begin
    if (mem_if.mem_clk) begin
      if (mem_if.mem_write) ram[mem_if.mem_addr] <= mem_if.mem_data;
      else                  mem_if.mem_q <= ram[mem_if.mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: expected cards queued by stimulus, popped by the monitor on each ack.
  logic [3:0] exp_q[$];
  int cyc = 0;
  int ack_count = 0;
  int last_ack = -1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    logic [3:0] e;
    @(negedge clk);
    if (rst_n === 1'b1 && draw_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {31'd0, draw_ack}, 0);
      end else begin
        e = exp_q.pop_front();
        check("card", {28'd0, card}, {28'd0, e});
        if (last_ack >= 0) check("ack_spacing", cyc - last_ack, 3);
        last_ack = cyc;
        ack_count++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_deck [52];

  task automatic wait_shuffler(output int n);
    n = 0;
    while (act_shuf !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int fill_cycles, strobes, n, cnt, bad;
    logic [5:0] j;
    logic [3:0] vi, vj, tmp;

    rst_n = 1'b0; new_game = 0; draw_req = 0; shuffled = 0;
    shuf_addr = '0; shuf_data = '0; shuf_write = 0; shuf_mclk = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_addr_j", addr_j, 33);
    check("rst_outputs", {deck_ready, deck_empty, act_shuf, draw_ack, card, cards_left}, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_port", {mem_if.mem_clk, mem_if.mem_write, mem_if.mem_addr,
                          mem_if.mem_data, deck_ready, act_shuf}, 0);
    end

    // Fill
    new_game = 1;
    @(negedge clk);
    new_game = 0;
    fill_cycles = 0; strobes = 0; n = 0;
    while (act_shuf !== 1'b1 && n < 300) begin
      if (mem_if.mem_write) fill_cycles++;
      if (mem_if.mem_clk) strobes++;
      @(negedge clk);
      n++;
    end
    check("fill_cycles", fill_cycles, 104);
    check("fill_strobes", strobes, 52);
    check("ram0", {28'd0, ram[0]}, 1);
    check("ram12", {28'd0, ram[12]}, 13);
    check("ram13", {28'd0, ram[13]}, 1);
    check("ram51", {28'd0, ram[51]}, 13);
    bad = 0;
    for (int k = 0; k < 52; k++) begin
      exp_deck[k] = 4'((k % 13) + 1);
      if (ram[k] !== exp_deck[k]) bad++;
    end
    check("fill_all", bad, 0);
    check("act_shuffler", {31'd0, act_shuf}, 1);

    // Shuffler model: swap RAM[i] with RAM[J] via two reads and two writes
    for (int i = 51; i >= 1; i--) begin
      j = addr_j;
      check("j_range", {31'd0, (addr_j < 6'd52)}, 1);
      shuf_addr = 6'(i); shuf_mclk = 1; shuf_write = 0;
      @(negedge clk);
      vi = mem_if.mem_q;
      shuf_addr = j;
      @(negedge clk);
      vj = mem_if.mem_q;
      shuf_addr = 6'(i); shuf_data = vj; shuf_write = 1;
      @(negedge clk);
      check("j_stable", addr_j, j);
      shuf_addr = j; shuf_data = vi;
      @(negedge clk);
      tmp = exp_deck[i]; exp_deck[i] = exp_deck[j]; exp_deck[j] = tmp;
    end
    shuf_mclk = 0; shuf_write = 0; shuffled = 1;
    @(negedge clk);
    shuffled = 0;
    check("ready", {31'd0, deck_ready}, 1);
    check("cards_left_full", cards_left, 52);
    check("shuf_off", {31'd0, act_shuf}, 0);
    for (int v = 1; v <= 13; v++) begin
      cnt = 0;
      for (int k = 0; k < 52; k++) if (ram[k] == 4'(v)) cnt++;
      check("histogram", cnt, 4);
    end
    bad = 0;
    for (int k = 0; k < 52; k++) if (ram[k] !== exp_deck[k]) bad++;
    check("shuffled_deck", bad, 0);

    // Draw the whole deck with a held request
    for (int k = 0; k < 52; k++) exp_q.push_back(exp_deck[k]);
    last_ack = -1; ack_count = 0;
    draw_req = 1;
    for (int t = 0; t < 400 && ack_count < 52; t++) @(negedge clk);
    check("draw_count", ack_count, 52);
    repeat (10) @(negedge clk);
    check("no_extra_ack", ack_count, 52);
    check("left_zero", cards_left, 0);
    check("deck_empty", {31'd0, deck_empty}, 1);
    draw_req = 0;

    // New game with an instant shuffle, then NewGame+DrawReq together in READY
    new_game = 1;
    @(negedge clk);
    new_game = 0;
    check("empty_drops", {31'd0, deck_empty}, 0);
    wait_shuffler(n);
    check("shuffle2_reached", {31'd0, act_shuf}, 1);
    shuffled = 1;
    @(negedge clk);
    shuffled = 0;
    check("ready2", {31'd0, deck_ready}, 1);
    check("left2", cards_left, 52);
    new_game = 1; draw_req = 1;
    @(negedge clk);
    new_game = 0; draw_req = 0;
    check("prio_fill", {deck_ready, mem_if.mem_write, cards_left}, {26'd0, 6'b010000 >> 4, 6'd0});
    repeat (4) @(negedge clk);
    check("prio_no_ack", ack_count, 52);

    // Asynchronous reset mid-SHUFFLE
    wait_shuffler(n);
    check("shuffle3_reached", {31'd0, act_shuf}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_act", {31'd0, act_shuf}, 0);
    check("async_j", addr_j, 33);
    check("async_out", {deck_ready, cards_left, mem_if.mem_clk}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {deck_ready, act_shuf, mem_if.mem_write, mem_if.mem_clk}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
